// File: rtl/vi_bus_update_pkg.sv
// rtl/vi_bus_update_pkg.sv - shared state type and counter constants for the bus update generator
package vi_bus_update_pkg;

   // Publish FSM: IDLE waits for an event, HOLD runs the hold-off window,
   // PEND holds an absorbed update until the hold-off window expires.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      PEND = 2'd2
   } state_t;

   // Width of the coalesced-event counter.
   localparam int COAL_W = 16;

   // Width of the hold-off counter; MIN_GAP-1 must fit.
   localparam int HOLDOFF_W = 16;

   // Saturating increment for the coalesce counter.
   function automatic logic [COAL_W-1:0] sat_inc(input logic [COAL_W-1:0] v);
      return (&v) ? v : v + COAL_W'(1);
   endfunction

endpackage

// File: rtl/vi_holdoff_cnt.sv
// rtl/vi_holdoff_cnt.sv - loadable down counter that stops at zero and flags it
module vi_holdoff_cnt #(
   parameter int           W       = 16,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec_en,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load has priority; decrement never wraps below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/vi_bus_update_gen.sv
// rtl/vi_bus_update_gen.sv - rate-limited publish strobe for a slow bus; periodic refresh under VI_BUS_UPDATE_REFRESH_EN
module vi_bus_update_gen
   import vi_bus_update_pkg::*;
#(
   parameter int SIZE           = 1,
   parameter int MIN_GAP        = 8,
   parameter int REFRESH_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SIZE-1:0]   in_bus,
   input  logic              force_req,
   output logic              out_pulse,
   output logic [SIZE-1:0]   out_bus,
   output logic              pending,
   output logic [COAL_W-1:0] coalesce_cnt
);

   // Reload value for the hold-off window: MIN_GAP cycles edge to edge.
   localparam logic [HOLDOFF_W-1:0] HOLD_LOAD = HOLDOFF_W'(MIN_GAP - 1);

   // Reject configurations the hold-off and refresh logic cannot honour.
   if ((MIN_GAP < 2) || (MIN_GAP > 65535) || (REFRESH_CYCLES <= MIN_GAP)) begin : g_bad_cfg
      $error("vi_bus_update_gen: illegal MIN_GAP/REFRESH_CYCLES");
   end

   state_t              state_q;
   logic [SIZE-1:0]     prev_q;
   logic                out_pulse_q;
   logic [SIZE-1:0]     out_bus_q;
   logic                pending_q;
   logic [COAL_W-1:0]   coal_q;

   logic                change_ev;
   logic                refresh_ev;
   logic                ev;
   logic                issue;
   logic                to_pend;
   logic                ho_zero;

   // Any source in a cycle collapses into a single event.
   assign change_ev = (in_bus != prev_q);
   assign ev        = change_ev | force_req | refresh_ev;

   // Publish now: straight from IDLE, at hold-off expiry with a fresh event,
   // or at hold-off expiry with an update already absorbed.
   assign issue = ((state_q == IDLE) && ev)
                | ((state_q == HOLD) && ho_zero && ev)
                | ((state_q == PEND) && ho_zero);

   // Next cycle is PEND when an update gets absorbed or remains absorbed.
   assign to_pend = ((state_q == HOLD) && !ho_zero && ev)
                  | ((state_q == PEND) && !ho_zero);

   vi_holdoff_cnt #(
      .W       (HOLDOFF_W),
      .RST_VAL ('0)
   ) u_holdoff (
      .clk      (clk),
      .rst      (rst),
      .load     (issue),
      .load_val (HOLD_LOAD),
      .dec_en   (state_q != IDLE),
      .zero     (ho_zero)
   );

`ifdef VI_BUS_UPDATE_REFRESH_EN
   // The refresh timer counts remaining cycles, so its reset/cleared value
   // REFRESH_CYCLES-1 corresponds to an elapsed count of zero, and reaching
   // zero corresponds to an elapsed count of REFRESH_CYCLES-1.
   localparam int              REF_W    = $clog2(REFRESH_CYCLES);
   localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRESH_CYCLES - 1);

   vi_holdoff_cnt #(
      .W       (REF_W),
      .RST_VAL (REF_LOAD)
   ) u_refresh (
      .clk      (clk),
      .rst      (rst),
      .load     (issue),
      .load_val (REF_LOAD),
      .dec_en   (1'b1),
      .zero     (refresh_ev)
   );
`else
   assign refresh_ev = 1'b0;
`endif

   // Publish FSM with registered strobe, data, pending flag and coalesce count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         out_pulse_q <= 1'b0;
         out_bus_q   <= '0;
         pending_q   <= 1'b0;
         coal_q      <= '0;
      end else begin
         prev_q      <= in_bus;
         out_pulse_q <= issue;
         pending_q   <= to_pend;
         if (issue) begin
            out_bus_q <= in_bus;
         end
         case (state_q)
            IDLE: begin
               if (issue) begin
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (ho_zero) begin
                  state_q <= ev ? HOLD : IDLE;
               end else if (ev) begin
                  state_q <= PEND;
               end
            end
            PEND: begin
               if (issue) begin
                  state_q <= HOLD;
               end else if (ev) begin
                  coal_q <= sat_inc(coal_q);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_pulse    = out_pulse_q;
   assign out_bus      = out_bus_q;
   assign pending      = pending_q;
   assign coalesce_cnt = coal_q;

endmodule

// File: tb/tb_vi_bus_update_gen.sv
// tb/tb_vi_bus_update_gen.sv - scoreboard bench for vi_bus_update_gen
module tb_vi_bus_update_gen;
   import vi_bus_update_pkg::*;

   localparam int MIN_GAP = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_bus = 8'h00;
   logic        force_req = 1'b0;
   logic        out_pulse;
   logic [7:0]  out_bus;
   logic        pending;
   logic [15:0] coalesce_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulse_cnt = 0;

   typedef struct {
      int         c;
      logic [7:0] d;
   } exp_t;
   exp_t exp_q[$];

   vi_bus_update_gen #(
      .SIZE           (8),
      .MIN_GAP        (MIN_GAP),
      .REFRESH_CYCLES (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_bus       (in_bus),
      .force_req    (force_req),
      .out_pulse    (out_pulse),
      .out_bus      (out_bus),
      .pending      (pending),
      .coalesce_cnt (coalesce_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Monitor: pops the scoreboard on every strobe, checks gap and bus hold.
   initial begin
      exp_t       e;
      int         last_pulse;
      logic [7:0] prev_bus;
      logic       rst_prev;
      last_pulse = -1000;
      prev_bus   = 8'h00;
      rst_prev   = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) last_pulse = -1000;
         if (out_pulse) begin
            pulse_cnt = pulse_cnt + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_pulse: got pulse at cyc %0d bus %h, required no pulse", cyc, out_bus);
            end else begin
               e = exp_q.pop_front();
               if (e.c != cyc || e.d !== out_bus) begin
                  errors = errors + 1;
                  $display("FAIL pulse: got cyc %0d bus %h, required cyc %0d bus %h", cyc, out_bus, e.c, e.d);
               end
            end
            checks = checks + 1;
            if (cyc - last_pulse < MIN_GAP) begin
               errors = errors + 1;
               $display("FAIL pulse_gap: got %0d cycles, required >= %0d", cyc - last_pulse, MIN_GAP);
            end
            last_pulse = cyc;
         end
         if (!rst && !rst_prev && !out_pulse && out_bus !== prev_bus) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL bus_hold: got %h without strobe, required %h", out_bus, prev_bus);
         end
         prev_bus = out_bus;
         rst_prev = rst;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset(output int base);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      base = cyc;
   endtask

   task automatic expect_pulse(input int c, input logic [7:0] d);
      exp_t e;
      e.c = c;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endtask

   task automatic end_test(input int c);
      wait_until(c);
      @(negedge clk);
      check("missing_pulses", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int         b;
      int         b2;
      int         pc0;
      int         pc1;
      int         chg_off [4];
      logic [7:0] chg_val [4];
      chg_off = '{10, 12, 14, 16};
      chg_val = '{8'h5A, 8'h11, 8'h22, 8'h33};

      // Steady zero bus: no publish (refresh build publishes at 64).
      in_bus = 8'h00;
      do_reset(b);
`ifdef VI_BUS_UPDATE_REFRESH_EN
      expect_pulse(b + 64, 8'h00);
`endif
      wait_until(b + 100);
      @(negedge clk);
      check("steady_coalesce", coalesce_cnt, 0);
      end_test(b + 101);

      // Single change: pulse next cycle, HOLD, then IDLE after the window.
      in_bus = 8'h00;
      do_reset(b);
      wait_until(b + 10);
      in_bus = 8'h5A;
      expect_pulse(b + 11, 8'h5A);
      wait_until(b + 11);
      @(negedge clk);
      check("state_after_issue", dut.state_q, HOLD);
      wait_until(b + 18);
      @(negedge clk);
      check("state_window_end", dut.state_q, HOLD);
      wait_until(b + 19);
      @(negedge clk);
      check("state_idle", dut.state_q, IDLE);
      end_test(b + 22);

      // Burst of changes: first published, rest coalesced into the latest.
      in_bus = 8'h00;
      do_reset(b);
      expect_pulse(b + 11, 8'h5A);
      expect_pulse(b + 19, 8'h33);
      for (int c = b + 1; c <= b + 20; c++) begin
         wait_until(c);
         for (int k = 0; k < 4; k++) begin
            if (c - b == chg_off[k]) in_bus = chg_val[k];
         end
         if (c >= b + 11 && c <= b + 19) begin
            @(negedge clk);
            check("pending", pending, (c >= b + 13 && c <= b + 18) ? 1 : 0);
         end
      end
      @(negedge clk);
      check("burst_coalesce", coalesce_cnt, 2);
      end_test(b + 30);

      // Continuous force for 40 cycles: five strobes in the window, one trailing.
      in_bus = 8'h00;
      do_reset(b);
      for (int k = 0; k < 6; k++) expect_pulse(b + 6 + 8 * k, 8'h00);
      wait_until(b + 5);
      force_req = 1'b1;
      pc0 = pulse_cnt;
      wait_until(b + 45);
      force_req = 1'b0;
      pc1 = pulse_cnt;
      check("force_window_pulses", pc1 - pc0, 5);
      wait_until(b + 50);
      @(negedge clk);
      check("force_coalesce", coalesce_cnt, 30);
      end_test(b + 52);

      // Reset while pending: update dropped, initial publish after release.
      in_bus = 8'h00;
      do_reset(b);
      wait_until(b + 3);
      in_bus = 8'h5A;
      expect_pulse(b + 4, 8'h5A);
      wait_until(b + 6);
      in_bus = 8'h3C;
      wait_until(b + 8);
      @(negedge clk);
      check("pending_before_rst", pending, 1);
      do_reset(b2);
      expect_pulse(b2 + 1, 8'h3C);
      @(negedge clk);
      check("rst_out_pulse", out_pulse, 0);
      check("rst_out_bus", out_bus, 0);
      check("rst_pending", pending, 0);
      check("rst_coalesce", coalesce_cnt, 0);
      check("rst_state", dut.state_q, IDLE);
      end_test(b2 + 20);

      // Constant bus: initial publish, then periodic refresh only with the macro.
      in_bus = 8'hA5;
      do_reset(b);
      expect_pulse(b + 1, 8'hA5);
`ifdef VI_BUS_UPDATE_REFRESH_EN
      expect_pulse(b + 65, 8'hA5);
      expect_pulse(b + 129, 8'hA5);
      expect_pulse(b + 193, 8'hA5);
`endif
      end_test(b + 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
